// File: rtl/fun_param_if.sv
// Handshake and operand bus for fun_param.
//   master: drives start, mode_i, a_i, b_i; receives busy, done, result
//   slave : the arithmetic unit side
// Widths follow the unit's A_W/B_W; result is A_W + ceil(B_W/2) bits wide.
interface fun_param_if #(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 8
);
  localparam int unsigned SQ_W  = (B_W + 1) / 2;
  localparam int unsigned RES_W = A_W + SQ_W;

  logic             start;
  logic             mode_i;
  logic [A_W-1:0]   a_i;
  logic [B_W-1:0]   b_i;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;

  modport master (output start, mode_i, a_i, b_i, input busy, done, result);
  modport slave  (input start, mode_i, a_i, b_i, output busy, done, result);
endinterface

// File: rtl/fun_param.sv
// fun_param: result = a * floor(root(b)), root = cube root (mode_i=0) or
// square root (mode_i=1). Sequential: one shared adder, first used by a
// digit-by-digit restoring root, then by an LSB-first shift-add multiply.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, highest priority
//   bus  - fun_param_if slave: start/mode_i/a_i/b_i in, busy/done/result out
// Latency is fixed per mode: cube 5*CB_W cycles, square 2*SQ_W cycles.
module fun_param #(
  parameter int unsigned A_W = 8,
  parameter int unsigned B_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  fun_param_if.slave  bus
);
  localparam int unsigned CB_W  = (B_W + 2) / 3;
  localparam int unsigned SQ_W  = (B_W + 1) / 2;
  localparam int unsigned RES_W = A_W + SQ_W;
  // radicand padded so it splits into whole 3-bit or 2-bit digits
  localparam int unsigned BP    = (3 * CB_W > 2 * SQ_W) ? 3 * CB_W : 2 * SQ_W;
  // adder/remainder width: remainder needs B_W+2 bits, product RES_W bits
  localparam int unsigned AW    = (B_W + 3 > RES_W) ? B_W + 3 : RES_W;
  localparam int unsigned CW    = $clog2(SQ_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ROOT = 2'd1, MUL = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [BP-1:0]    b_q, b_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [SQ_W-1:0]  r_q, r_d;    // root so far; multiplier during MUL
  logic [AW-1:0]    r2_q, r2_d;  // r^2 for cube; shifted multiplicand during MUL
  logic [AW-1:0]    s_q, s_d;    // cube trial scratch; accumulator during MUL
  logic [1:0]       ph_q, ph_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             done_q, done_d;

  logic [AW-1:0]    add_x, add_y, rem_sh;
  logic             add_ci, step_end;
  logic [AW:0]      add_s;

  assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{AW{1'b0}}, add_ci};

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    r_d      = r_q;
    r2_d     = r2_q;
    s_d      = s_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    done_d   = 1'b0;
    add_x    = '0;
    add_y    = '0;
    add_ci   = 1'b0;
    rem_sh   = '0;
    step_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ROOT;
          mode_d  = bus.mode_i;
          a_d     = bus.a_i;
          b_d     = bus.mode_i ? (BP'(bus.b_i) << (BP - 2 * SQ_W))
                               : (BP'(bus.b_i) << (BP - 3 * CB_W));
          rem_d   = '0;
          r_d     = '0;
          r2_d    = '0;
          s_d     = '0;
          ph_d    = '0;
          cnt_d   = bus.mode_i ? CW'(SQ_W) : CW'(CB_W);
        end
      end
      ROOT: begin
        if (mode_q) begin
          // square step: trial 4r+1, subtract via carry-in
          rem_sh = {rem_q[AW-3:0], b_q[BP-1 -: 2]};
          add_x  = rem_sh;
          add_y  = ~AW'({r_q, 2'b01});
          add_ci = 1'b1;
          b_d    = b_q << 2;
          if (add_s[AW]) begin
            rem_d = add_s[AW-1:0];
            r_d   = (r_q << 1) | SQ_W'(1);
          end else begin
            rem_d = rem_sh;
            r_d   = r_q << 1;
          end
          step_end = 1'b1;
        end else begin
          // cube step over four adder cycles with R=2r, R2=4r^2:
          // trial = 3*(R2+R)+1; on success r2 += 2R+1
          ph_d = ph_q + 2'd1;
          case (ph_q)
            2'd0: begin
              rem_d = {rem_q[AW-4:0], b_q[BP-1 -: 3]};
              b_d   = b_q << 3;
              r_d   = r_q << 1;
              r2_d  = r2_q << 2;
              add_x = r2_q << 2;
              add_y = AW'(r_q) << 1;
              s_d   = add_s[AW-1:0];
            end
            2'd1: begin
              add_x  = s_q;
              add_y  = s_q << 1;
              add_ci = 1'b1;
              s_d    = add_s[AW-1:0];
            end
            2'd2: begin
              add_x  = rem_q;
              add_y  = ~s_q;
              add_ci = 1'b1;
              if (add_s[AW]) begin
                rem_d = add_s[AW-1:0];
                r_d   = r_q | SQ_W'(1);
              end
            end
            default: begin
              // r_q[0] is the digit just decided; R itself is r_q with bit 0 cleared
              add_x  = r2_q;
              add_y  = AW'(r_q >> 1) << 2;
              add_ci = 1'b1;
              if (r_q[0]) r2_d = add_s[AW-1:0];
              step_end = 1'b1;
            end
          endcase
        end
        if (step_end) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = MUL;
            cnt_d   = mode_q ? CW'(SQ_W) : CW'(CB_W);
            s_d     = '0;
            r2_d    = AW'(a_q);
          end
        end
      end
      MUL: begin
        add_x = s_q;
        add_y = r_q[0] ? r2_q : '0;
        s_d   = add_s[AW-1:0];
        r2_d  = r2_q << 1;
        r_d   = r_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          res_d   = add_s[RES_W-1:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      r_q     <= '0;
      r2_q    <= '0;
      s_q     <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
      r2_q    <= r2_d;
      s_q     <= s_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = res_q;
endmodule

// File: tb/tb_fun_param.sv
// Bench for fun_param: two instances (8/8 and 12/16), scoreboard queue of
// expected products, brute-force root reference model.
module tb_fun_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fun_param_if #(.A_W(8),  .B_W(8))  if0 ();
  fun_param_if #(.A_W(12), .B_W(16)) if1 ();

  fun_param #(.A_W(8),  .B_W(8))  u0 (.clk(clk), .rst(rst), .bus(if0));
  fun_param #(.A_W(12), .B_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int lat_ref[2][2];

  function automatic longint unsigned icbrt(longint unsigned b);
    longint unsigned r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  function automatic longint unsigned isqrt(longint unsigned b);
    longint unsigned r = 0;
    while ((r + 1) * (r + 1) <= b) r++;
    return r;
  endfunction

  function automatic logic [63:0] model(bit m, longint unsigned a, longint unsigned b);
    return a * (m ? isqrt(b) : icbrt(b));
  endfunction

  task automatic drive(input int d, input bit st, input bit m,
                       input logic [11:0] a, input logic [15:0] b);
    if (d == 0) begin
      if0.start = st; if0.mode_i = m; if0.a_i = a[7:0]; if0.b_i = b[7:0];
    end else begin
      if1.start = st; if1.mode_i = m; if1.a_i = a; if1.b_i = b;
    end
  endtask

  function automatic logic get_done(int d);
    return (d == 0) ? if0.done : if1.done;
  endfunction

  function automatic logic get_busy(int d);
    return (d == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic [63:0] get_res(int d);
    return (d == 0) ? 64'(if0.result) : 64'(if1.result);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // caller has already passed the accept edge
  task automatic wait_done(input int d, output int lat, output bit tmo);
    lat = 1;
    tmo = 1'b0;
    while (get_done(d) !== 1'b1) begin
      if (lat >= 200) begin
        tmo = 1'b1;
        break;
      end
      tick;
      lat++;
    end
  endtask

  task automatic run_op(input int d, input bit m, input logic [11:0] a, input logic [15:0] b,
                        output logic [63:0] res, output int lat, output bit tmo);
    drive(d, 1'b1, m, a, b);
    tick;
    drive(d, 1'b0, m, a, b);
    wait_done(d, lat, tmo);
    res = get_res(d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst = 1'b0;
      tick;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({get_busy(d), get_done(d)} !== 2'b00 || get_res(d) !== 64'd0) begin
          errors++;
          $display("FAIL reset d%0d cyc%0d: busy=%b done=%b result=%0d, required 0/0/0",
                   d, i, get_busy(d), get_done(d), get_res(d));
        end
      end
    end
  endtask

  task automatic test_cube;
    int va[4] = '{5, 255, 3, 0};
    int vb[4] = '{27, 255, 0, 125};
    int ve[4] = '{15, 1530, 0, 0};
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'(ve[i]));
      run_op(0, 1'b0, 12'(va[i]), 16'(vb[i]), res, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || res !== exp) begin
        errors++;
        $display("FAIL cube a=%0d b=%0d: result=%0d timeout=%0d, required %0d", va[i], vb[i], res, tmo, exp);
      end
      checks++;
      if (get_busy(0) !== 1'b0) begin
        errors++;
        $display("FAIL cube_busy_in_done: busy=%b, required 0", get_busy(0));
      end
      if (lat_ref[0][0] < 0) lat_ref[0][0] = lat;
      else begin
        checks++;
        if (lat != lat_ref[0][0]) begin
          errors++;
          $display("FAIL cube_latency: %0d, required %0d", lat, lat_ref[0][0]);
        end
      end
      tick;
      checks++;
      if (get_done(0) !== 1'b0) begin
        errors++;
        $display("FAIL cube_done_pulse: done=%b one cycle later, required 0", get_done(0));
      end
    end
  endtask

  task automatic test_sqrt;
    int va[4] = '{255, 7, 200, 0};
    int vb[4] = '{255, 99, 0, 255};
    int ve[4] = '{3825, 63, 0, 0};
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'(ve[i]));
      run_op(0, 1'b1, 12'(va[i]), 16'(vb[i]), res, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || res !== exp) begin
        errors++;
        $display("FAIL sqrt a=%0d b=%0d: result=%0d timeout=%0d, required %0d", va[i], vb[i], res, tmo, exp);
      end
      if (lat_ref[0][1] < 0) lat_ref[0][1] = lat;
      else begin
        checks++;
        if (lat != lat_ref[0][1]) begin
          errors++;
          $display("FAIL sqrt_latency: %0d, required %0d", lat, lat_ref[0][1]);
        end
      end
      tick;
      checks++;
      if (get_done(0) !== 1'b0) begin
        errors++;
        $display("FAIL sqrt_done_pulse: done=%b one cycle later, required 0", get_done(0));
      end
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] exp;
    int lat;
    bit tmo;
    exp_q.push_back(64'd36);
    drive(0, 1'b1, 1'b0, 12'd9, 16'd64);
    tick;
    lat = 1;
    tmo = 1'b0;
    while (get_done(0) !== 1'b1) begin
      if (lat >= 200) begin
        tmo = 1'b1;
        break;
      end
      drive(0, 1'($urandom), 1'($urandom), 12'($urandom), 16'($urandom));
      tick;
      lat++;
    end
    drive(0, 1'b0, 1'b0, 12'd0, 16'd0);
    exp = exp_q.pop_front();
    checks++;
    if (tmo || get_res(0) !== exp) begin
      errors++;
      $display("FAIL busy_ignore_result: %0d timeout=%0d, required %0d", get_res(0), tmo, exp);
    end
    checks++;
    if (lat != lat_ref[0][0]) begin
      errors++;
      $display("FAIL busy_ignore_latency: %0d, required %0d", lat, lat_ref[0][0]);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    exp_q.push_back(64'd120);
    run_op(0, 1'b1, 12'd10, 16'd144, res, lat, tmo);
    exp = exp_q.pop_front();
    checks++;
    if (tmo || res !== exp) begin
      errors++;
      $display("FAIL b2b_first: %0d timeout=%0d, required %0d", res, tmo, exp);
    end
    // start during the done cycle itself
    exp_q.push_back(64'd35);
    drive(0, 1'b1, 1'b0, 12'd7, 16'd125);
    tick;
    drive(0, 1'b0, 1'b0, 12'd7, 16'd125);
    checks++;
    if (get_busy(0) !== 1'b1 || get_res(0) !== 64'd120) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b result=%0d, required 1/120", get_busy(0), get_res(0));
    end
    wait_done(0, lat, tmo);
    exp = exp_q.pop_front();
    checks++;
    if (tmo || get_res(0) !== exp || lat != lat_ref[0][0]) begin
      errors++;
      $display("FAIL b2b_second: result=%0d lat=%0d timeout=%0d, required %0d lat %0d",
               get_res(0), lat, tmo, exp, lat_ref[0][0]);
    end
    tick;
  endtask

  task automatic test_reset_abort;
    logic [63:0] res, exp;
    int lat, dones;
    bit tmo;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(64'd500);
      run_op(0, 1'b0, 12'd100, 16'd200, res, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || res !== exp) begin
        errors++;
        $display("FAIL abort_pre%0d: %0d, required %0d", k, res, exp);
      end
      drive(0, 1'b1, 1'b0, 12'd50, 16'd100);
      tick;
      drive(0, 1'b0, 1'b0, 12'd50, 16'd100);
      // k=0: stop early in ROOT; k=1: stop inside MUL (13 edges after accept)
      for (int i = 0; i < ((k == 0) ? 2 : 12); i++) tick;
      checks++;
      if (get_busy(0) !== 1'b1) begin
        errors++;
        $display("FAIL abort_busy_before%0d: busy=%b, required 1", k, get_busy(0));
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if (get_busy(0) !== 1'b0 || get_done(0) !== 1'b0 || get_res(0) !== 64'd0) begin
        errors++;
        $display("FAIL abort%0d: busy=%b done=%b result=%0d, required 0/0/0",
                 k, get_busy(0), get_done(0), get_res(0));
      end
      dones = 0;
      for (int i = 0; i < 20; i++) begin
        tick;
        if (get_done(0) !== 1'b0) dones++;
      end
      checks++;
      if (dones != 0) begin
        errors++;
        $display("FAIL abort_no_done%0d: %0d done cycles, required 0", k, dones);
      end
      exp_q.push_back(64'd63);
      run_op(0, 1'b1, 12'd7, 16'd99, res, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || res !== exp) begin
        errors++;
        $display("FAIL abort_fresh%0d: %0d timeout=%0d, required %0d", k, res, tmo, exp);
      end
      tick;
    end
  endtask

  task automatic test_sweep(input int d);
    logic [63:0] res, exp;
    int lat, n, bmax, amax, bound;
    bit tmo;
    logic [15:0] b;
    logic [11:0] a;
    bmax  = (d == 0) ? 255 : 65535;
    amax  = (d == 0) ? 255 : 4095;
    bound = (d == 0) ? 6 * 8 + 4 : 6 * 16 + 4;
    n     = (d == 0) ? 256 : 202;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < n; i++) begin
        if (d == 0) b = 16'(i);
        else if (i == 0) b = 16'd0;
        else if (i == 1) b = 16'(bmax);
        else b = 16'($urandom_range(0, bmax));
        a = (i == 1) ? 12'(amax) : 12'($urandom_range(0, amax));
        exp_q.push_back(model(m[0], a, b));
        run_op(d, m[0], a, b, res, lat, tmo);
        exp = exp_q.pop_front();
        checks++;
        if (tmo || res !== exp) begin
          errors++;
          $display("FAIL sweep d%0d m%0d a=%0d b=%0d: result=%0d timeout=%0d, required %0d",
                   d, m, a, b, res, tmo, exp);
        end
        if (lat_ref[d][m] < 0) lat_ref[d][m] = lat;
        checks++;
        if (lat != lat_ref[d][m] || lat > bound) begin
          errors++;
          $display("FAIL sweep_latency d%0d m%0d: %0d, required %0d and <= %0d",
                   d, m, lat, lat_ref[d][m], bound);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++) lat_ref[d][m] = -1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 12'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 12'd0, 16'd0);
    test_reset;
    test_cube;
    test_sqrt;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    test_sweep(0);
    test_sweep(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
